// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state codes and default timing constants for the stopwatch controller
// No ports; imported by btn_cond and stopwatch_ctrl.
package stopwatch_pkg;
  localparam int STATE_W = 3;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_CLR_CYCLES = 4;
  typedef enum logic [STATE_W-1:0] {
    CLEAR   = 3'd0,
    ZERO    = 3'd1,
    RUN     = 3'd2,
    LAP     = 3'd3,
    STOPPED = 3'd4
  } state_t;
endpackage

// File: rtl/stopwatch_ctrl_btn_cond.sv
// btn_cond: synchronise, debounce and edge-detect one raw push-button
// Ports: CLK, RESET (async, active-high), raw (async button), level (debounced), press (one-cycle rising pulse)
import stopwatch_pkg::*;
module btn_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic CLK,
  input  logic RESET,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic level_d;
  logic synced;
  assign synced = sync[SYNC_STAGES-1];
  assign press = level & ~level_d;
  // level resets high so a button held through reset never yields a press
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      sync <= '0;
      cnt <= '0;
      level <= 1'b1;
      level_d <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      level_d <= level;
      if (synced == level)
        cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= ~level;
        cnt <= '0;
      end else
        cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/lap/clear controller gating the stopwatch counter chain
// Ports: CLK, RESET (async, active-high), STRTSTOP/LAPRST (raw buttons), locked (clock-manager lock),
//        CLKEN/RST/HOLD (registered counter/display controls), LOCK_ERR (sticky lock-loss), STATE (debug code)
import stopwatch_pkg::*;
module stopwatch_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CLR_CYCLES = DEF_CLR_CYCLES
) (
  input  logic CLK,
  input  logic RESET,
  input  logic STRTSTOP,
  input  logic LAPRST,
  input  logic locked,
  output logic CLKEN,
  output logic RST,
  output logic HOLD,
  output logic LOCK_ERR,
  output logic [STATE_W-1:0] STATE
);
  localparam int CW = CLR_CYCLES > 1 ? $clog2(CLR_CYCLES) : 1;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic lock_s, start_p, lap_p, start_lvl, lap_lvl, unused_lvl, err_n;
  logic [STATE_W-1:0] state_q;
  logic [CW-1:0] cnt;
  state_t nxt;
  assign lock_s = lock_sync[SYNC_STAGES-1];
  assign unused_lvl = start_lvl ^ lap_lvl;
  assign STATE = state_q;
  btn_cond #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .CLK(CLK), .RESET(RESET), .raw(STRTSTOP), .level(start_lvl), .press(start_p)
  );
  btn_cond #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (
    .CLK(CLK), .RESET(RESET), .raw(LAPRST), .level(lap_lvl), .press(lap_p)
  );
  // start takes precedence over lap everywhere, so a simultaneous lap press is dropped
  always_comb begin
    nxt = CLEAR;
    err_n = LOCK_ERR;
    case (state_q)
      CLEAR:   nxt = cnt == '0 ? ZERO : CLEAR;
      ZERO:    nxt = start_p && lock_s ? RUN : ZERO;
      RUN, LAP: begin
        nxt = !lock_s || start_p ? STOPPED : lap_p ? (state_q == RUN ? LAP : RUN) : (state_q == RUN ? RUN : LAP);
        err_n = LOCK_ERR | ~lock_s;
      end
      STOPPED: nxt = start_p ? (lock_s ? RUN : STOPPED) : lap_p ? CLEAR : STOPPED;
      default: nxt = CLEAR;
    endcase
    if (nxt == CLEAR) err_n = 1'b0;
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      lock_sync <= '0;
      state_q <= CLEAR;
      cnt <= CW'(CLR_CYCLES - 1);
      RST <= 1'b1;
      CLKEN <= 1'b0;
      HOLD <= 1'b0;
      LOCK_ERR <= 1'b0;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], locked};
      state_q <= nxt;
      cnt <= state_q == CLEAR && nxt == CLEAR ? cnt - CW'(1) : CW'(CLR_CYCLES - 1);
      RST <= nxt == CLEAR;
      CLKEN <= nxt == RUN || nxt == LAP;
      HOLD <= nxt == LAP;
      LOCK_ERR <= err_n;
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed scenarios plus randomized run against a behavioural model of stopwatch_ctrl
module tb_stopwatch_ctrl;
  localparam int SYNC = 2, DEB = 4, CLR = 3;
  logic CLK = 1'b0, RESET = 1'b1, STRTSTOP = 1'b0, LAPRST = 1'b0, locked = 1'b1;
  logic CLKEN, RST, HOLD, LOCK_ERR;
  logic [2:0] STATE;
  int checks = 0, passes = 0;
  bit q_s[$], q_l[$], q_k[$];
  bit lev[2], pr[2];
  int run[2];
  int es, rl;
  bit ele;

  stopwatch_ctrl #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CLR_CYCLES(CLR)) dut (
    .CLK(CLK), .RESET(RESET), .STRTSTOP(STRTSTOP), .LAPRST(LAPRST), .locked(locked),
    .CLKEN(CLKEN), .RST(RST), .HOLD(HOLD), .LOCK_ERR(LOCK_ERR), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  function automatic void model_reset();
    q_s = {}; q_l = {}; q_k = {};
    for (int i = 0; i < SYNC; i++) begin q_s.push_back(0); q_l.push_back(0); q_k.push_back(0); end
    lev = '{1, 1}; pr = '{0, 0}; run = '{0, 0};
    es = 0; rl = CLR; ele = 0;
  endfunction

  // one clock edge of behaviour: states 0 CLEAR,1 ZERO,2 RUN,3 LAP,4 STOPPED
  function automatic void model_step();
    bit sp, lp, lk;
    bit syn[2];
    sp = pr[0]; lp = pr[1]; lk = q_k[0];
    case (es)
      0: begin rl--; if (rl == 0) es = 1; end
      1: if (sp && lk) es = 2;
      2, 3: if (!lk) begin es = 4; ele = 1; end
            else if (sp) es = 4;
            else if (lp) es = (es == 2) ? 3 : 2;
      4: if (sp) begin if (lk) es = 2; end
         else if (lp) begin es = 0; rl = CLR; end
      default: es = 0;
    endcase
    if (es == 0) ele = 0;
    syn[0] = q_s[0]; syn[1] = q_l[0];
    for (int b = 0; b < 2; b++) begin
      pr[b] = 0;
      if (syn[b] != lev[b]) begin
        run[b]++;
        if (run[b] == DEB) begin lev[b] = ~lev[b]; run[b] = 0; pr[b] = lev[b]; end
      end else run[b] = 0;
    end
    void'(q_s.pop_front()); q_s.push_back(STRTSTOP);
    void'(q_l.pop_front()); q_l.push_back(LAPRST);
    void'(q_k.pop_front()); q_k.push_back(locked);
  endfunction

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    model_reset();
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
  endtask

  task automatic hold_btn(input bit s, input bit l, input int n);
    STRTSTOP = s; LAPRST = l;
    repeat (n) tick();
  endtask

  task automatic release_btn();
    STRTSTOP = 0; LAPRST = 0;
    repeat (8) tick();
  endtask

  task automatic press(input bit s, input bit l);
    hold_btn(s, l, 10);
    release_btn();
  endtask

  task automatic test_reset();
    locked = 1;
    RESET = 1'b1;
    model_reset();
    @(posedge CLK); #1;
    checks++; if (RST !== 1'b1 || CLKEN !== 1'b0 || STATE !== 3'd0) $display("FAIL reset_vals RST=%b CLKEN=%b STATE=%0d exp 1 0 0", RST, CLKEN, STATE); else passes++;
    @(posedge CLK); #1 RESET = 1'b0;
    tick(); tick();
    checks++; if (RST !== 1'b1 || STATE !== 3'd0) $display("FAIL reset_rst_len RST=%b STATE=%0d exp 1 0", RST, STATE); else passes++;
    tick();
    checks++; if (RST !== 1'b0 || STATE !== 3'd1 || CLKEN !== 1'b0) $display("FAIL reset_zero RST=%b STATE=%0d CLKEN=%b exp 0 1 0", RST, STATE, CLKEN); else passes++;
    repeat (10) tick();
    checks++; if (STATE !== 3'd1) $display("FAIL reset_no_press STATE=%0d exp 1", STATE); else passes++;
  endtask

  task automatic test_start_stop();
    hold_btn(1, 0, 6);
    checks++; if (CLKEN !== 1'b0 || STATE !== 3'd1) $display("FAIL start_early CLKEN=%b STATE=%0d exp 0 1", CLKEN, STATE); else passes++;
    tick();
    checks++; if (CLKEN !== 1'b1 || STATE !== 3'd2) $display("FAIL start_run CLKEN=%b STATE=%0d exp 1 2", CLKEN, STATE); else passes++;
    hold_btn(1, 0, 3);
    release_btn();
    hold_btn(1, 0, 6);
    checks++; if (STATE !== 3'd2) $display("FAIL stop_early STATE=%0d exp 2", STATE); else passes++;
    tick();
    checks++; if (STATE !== 3'd4 || CLKEN !== 1'b0) $display("FAIL stop STATE=%0d CLKEN=%b exp 4 0", STATE, CLKEN); else passes++;
    hold_btn(1, 0, 3);
    release_btn();
    press(1, 0);
    checks++; if (STATE !== 3'd2) $display("FAIL restart STATE=%0d exp 2", STATE); else passes++;
  endtask

  task automatic test_lap();
    press(0, 1);
    checks++; if (HOLD !== 1'b1 || CLKEN !== 1'b1 || STATE !== 3'd3) $display("FAIL lap HOLD=%b CLKEN=%b STATE=%0d exp 1 1 3", HOLD, CLKEN, STATE); else passes++;
    press(0, 1);
    checks++; if (HOLD !== 1'b0 || STATE !== 3'd2) $display("FAIL unlap HOLD=%b STATE=%0d exp 0 2", HOLD, STATE); else passes++;
    hold_btn(1, 0, 3);
    release_btn();
    checks++; if (STATE !== 3'd2) $display("FAIL glitch STATE=%0d exp 2", STATE); else passes++;
  endtask

  task automatic test_lock_loss();
    locked = 0;
    tick(); tick();
    checks++; if (STATE !== 3'd2) $display("FAIL lock_early STATE=%0d exp 2", STATE); else passes++;
    tick();
    checks++; if (STATE !== 3'd4 || CLKEN !== 1'b0 || LOCK_ERR !== 1'b1) $display("FAIL lock_loss STATE=%0d CLKEN=%b LOCK_ERR=%b exp 4 0 1", STATE, CLKEN, LOCK_ERR); else passes++;
    tick(); tick();
    press(1, 0);
    checks++; if (STATE !== 3'd4 || LOCK_ERR !== 1'b1) $display("FAIL nolock_start STATE=%0d LOCK_ERR=%b exp 4 1", STATE, LOCK_ERR); else passes++;
    locked = 1;
    repeat (3) tick();
    hold_btn(0, 1, 7);
    checks++; if (STATE !== 3'd0 || RST !== 1'b1 || LOCK_ERR !== 1'b0) $display("FAIL clear STATE=%0d RST=%b LOCK_ERR=%b exp 0 1 0", STATE, RST, LOCK_ERR); else passes++;
    tick(); tick();
    checks++; if (RST !== 1'b1) $display("FAIL clear_len RST=%b exp 1", RST); else passes++;
    tick();
    checks++; if (RST !== 1'b0 || STATE !== 3'd1) $display("FAIL clear_end RST=%b STATE=%0d exp 0 1", RST, STATE); else passes++;
    release_btn();
  endtask

  task automatic test_back_to_back();
    press(1, 0);
    press(0, 1);
    checks++; if (STATE !== 3'd3) $display("FAIL b2b_lap STATE=%0d exp 3", STATE); else passes++;
    press(1, 1);
    checks++; if (STATE !== 3'd4 || HOLD !== 1'b0 || CLKEN !== 1'b0) $display("FAIL both STATE=%0d HOLD=%b CLKEN=%b exp 4 0 0", STATE, HOLD, CLKEN); else passes++;
    repeat (5) tick();
    checks++; if (STATE !== 3'd4) $display("FAIL both_noclear STATE=%0d exp 4", STATE); else passes++;
  endtask

  task automatic test_reset_held();
    STRTSTOP = 1;
    do_reset();
    repeat (12) tick();
    checks++; if (STATE !== 3'd1) $display("FAIL held_reset STATE=%0d exp 1", STATE); else passes++;
    release_btn();
    press(1, 0);
    press(0, 1);
    checks++; if (HOLD !== 1'b1) $display("FAIL pre_async HOLD=%b exp 1", HOLD); else passes++;
    RESET = 1'b1;
    #1;
    checks++; if (RST !== 1'b1 || CLKEN !== 1'b0 || HOLD !== 1'b0 || STATE !== 3'd0) $display("FAIL async_reset RST=%b CLKEN=%b HOLD=%b STATE=%0d exp 1 0 0 0", RST, CLKEN, HOLD, STATE); else passes++;
    do_reset();
  endtask

  task automatic test_random();
    for (int n = 0; n < 200; n++) begin
      STRTSTOP = 1'($urandom_range(0, 1));
      LAPRST = 1'($urandom_range(0, 1));
      locked = $urandom_range(0, 7) != 0;
      repeat ($urandom_range(1, 14)) begin
        tick();
        checks++;
        if (STATE !== 3'(es) || RST !== (es == 0) || CLKEN !== (es == 2 || es == 3) || HOLD !== (es == 3) || LOCK_ERR !== ele)
          $display("FAIL random t=%0t STATE=%0d RST=%b CLKEN=%b HOLD=%b LOCK_ERR=%b exp %0d %b %b %b %b",
                   $time, STATE, RST, CLKEN, HOLD, LOCK_ERR, es, es == 0, es == 2 || es == 3, es == 3, ele);
        else passes++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_stop();
    test_lap();
    test_lock_loss();
    test_back_to_back();
    test_reset_held();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Parametrised run/lap controller for the stopwatch counter chain. Conditions two raw push-buttons (start/stop and lap/reset) and gates counting on clock-manager lock. Drives glitch-free registered RST, CLKEN and HOLD to the BCD counter and display-latch blocks. Adds lap-freeze, a multi-cycle clear pulse, button debounce and a sticky lock-loss flag.

Parameters:
SYNC_STAGES, 2, synchroniser flops per button input; legal range 2..4
DEBOUNCE_CYCLES, 16, consecutive agreeing samples needed to change a debounced level; legal range 2..65535
CLR_CYCLES, 4, RST pulse length in CLK cycles when in CLEAR; legal range 1..255

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  asynchronous, active-high reset
STRTSTOP  input  1  raw start/stop button, asynchronous, active-high
LAPRST  input  1  raw lap/reset button, asynchronous, active-high
locked  input  1  clock-manager lock, asynchronous
CLKEN  output  1  registered count enable to counter chain
RST  output  1  registered synchronous clear to counter chain
HOLD  output  1  registered display-freeze (lap) to display latch
LOCK_ERR  output  1  registered sticky flag: lock lost while running
STATE  output  3  registered state code, for debug/LEDs

Behaviour:
- Reset, asynchronous: state=CLEAR, clear counter=CLR_CYCLES-1, RST=1, CLKEN=0, HOLD=0, LOCK_ERR=0, STATE=0. Synchroniser flops=0. Debounced levels=1, so a button held through reset gives no press event. Debounce counters=0.
- locked passes through SYNC_STAGES flops. No debounce.
- Button conditioning, per button: SYNC_STAGES flop chain, then counter. The counter increments while the synced level differs from the debounced level, and clears when they agree. When DEBOUNCE_CYCLES consecutive differing samples are seen, the debounced level toggles and the counter clears. Press = debounced rising edge, a one-cycle pulse.
- Press latency: with the first CLK edge sampling the button high counted as edge 1, the FSM acts at edge SYNC_STAGES+DEBOUNCE_CYCLES+1. Pulses shorter than DEBOUNCE_CYCLES samples are rejected.
- Outputs are decoded from next-state and registered, so they change on the same edge as the state register. No combinational path from inputs to outputs.
- States / STATE codes: CLEAR=0, ZERO=1, RUN=2, LAP=3, STOPPED=4. Codes 5..7 are illegal and go to CLEAR on the next edge.
- CLEAR: RST=1, CLKEN=0, HOLD=0, LOCK_ERR cleared. Counter decrements each cycle; at 0, go to ZERO. Presses are ignored. RST is high for exactly CLR_CYCLES cycles.
- ZERO: start press & lock_s → RUN. Start press with lock_s=0 is discarded. Lap press ignored.
- RUN: CLKEN=1.
  - lock_s=0 → STOPPED, LOCK_ERR set; this has highest priority.
  - Otherwise start press → STOPPED.
  - Otherwise lap press → LAP.
- LAP: CLKEN=1, HOLD=1.
  - lock_s=0 → STOPPED, LOCK_ERR set, HOLD cleared.
  - Otherwise start press → STOPPED, HOLD cleared.
  - Otherwise lap press → RUN, HOLD cleared.
- STOPPED: CLKEN=0.
  - start press & lock_s → RUN.
  - Otherwise lap press → CLEAR.
- Simultaneous start and lap presses in the same cycle: start wins and the lap press is dropped.
- LOCK_ERR is set only by the RUN/LAP lock-loss transitions and cleared only in CLEAR or by RESET.
- RESET asserted mid-operation: immediate return to reset values. The debounce counters' partial counts are lost.

Decomposition:
- Shared package stopwatch_pkg holds:
  - state encoding constants (CLEAR..STOPPED, 3-bit)
  - STATE_W=3
  - the default DEBOUNCE_CYCLES and CLR_CYCLES values
- Sub-module btn_cond, instantiated twice:
  - parameters SYNC_STAGES, DEBOUNCE_CYCLES
  - ports CLK, RESET, raw in, debounced level out, press pulse out
  - counter width = clog2(DEBOUNCE_CYCLES+1)
- The top level holds the locked synchroniser, the FSM, the clear counter and the output registers.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, CLR_CYCLES=3; press latency 7 edges):
- Reset release with buttons low, locked=1: RST=1 for 3 cycles, then STATE=1, CLKEN=0; no spurious press.
- Start press (held 10 cycles) in ZERO, locked=1: CLKEN rises at edge 7, STATE=2. A second press gives STATE=4, CLKEN=0 after 7 more edges.
- In RUN, lap press: HOLD=1, CLKEN=1, STATE=3. A second lap press gives HOLD=0, STATE=2. A 3-cycle STRTSTOP glitch gives no state change.
- In RUN, drop locked for 5 cycles: STATE=4, CLKEN=0, LOCK_ERR=1 after 3 edges. Start press with locked=0 stays STOPPED. Lap press gives CLEAR with LOCK_ERR=0 and RST=1 for 3 cycles.
- Both buttons pressed in the same cycle in LAP: STATE=4, HOLD=0, CLKEN=0; no CLEAR follows.
- Button held high across RESET: no press event after release. Assert RESET in RUN: RST=1, CLKEN=0 and HOLD=0 immediately (asynchronous).
